// File: rtl/wb_byte_master.sv
// Single-outstanding Wishbone initiator that moves one byte per command to an 8-bit responder.
// Optional STB timeout is enabled by defining WB_BYTE_MASTER_TIMEOUT_EN.
`timescale 1ns/1ps

module wb_byte_master #(
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic       CLK_I,
  input  logic       RST_I,
  input  logic       CMD_VALID,
  output logic       CMD_READY,
  input  logic       CMD_WE,
  input  logic [7:0] CMD_WDATA,
  output logic       RSP_VALID,
  output logic [7:0] RSP_RDATA,
  output logic       RSP_ERR,
  output logic       STB_O,
  output logic       WE_O,
  output logic [7:0] DAT_O,
  input  logic [7:0] DAT_I,
  input  logic       ACK_I
);

  localparam int unsigned DW = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RSP  = 2'd2
  } state_t;

  generate
    if (TIMEOUT_CYC < 1) begin : g_bad_timeout
      $error("wb_byte_master: TIMEOUT_CYC must be at least 1");
    end
  endgenerate

  state_t          state, state_n;
  logic            stb_n, we_n, rsp_valid_n, rsp_err_n;
  logic [DW-1:0]   dat_n, rsp_rdata_n;

`ifdef WB_BYTE_MASTER_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

  logic [CW-1:0] cnt, cnt_n;
`endif

  assign CMD_READY = (state == IDLE);

  // State and registered outputs.
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      state     <= IDLE;
      STB_O     <= 1'b0;
      WE_O      <= 1'b0;
      DAT_O     <= '0;
      RSP_VALID <= 1'b0;
      RSP_RDATA <= '0;
      RSP_ERR   <= 1'b0;
    end else begin
      state     <= state_n;
      STB_O     <= stb_n;
      WE_O      <= we_n;
      DAT_O     <= dat_n;
      RSP_VALID <= rsp_valid_n;
      RSP_RDATA <= rsp_rdata_n;
      RSP_ERR   <= rsp_err_n;
    end
  end

`ifdef WB_BYTE_MASTER_TIMEOUT_EN
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_n;
    end
  end
`endif

  // Next-state and next-output logic.
  always_comb begin
    state_n     = state;
    stb_n       = STB_O;
    we_n        = WE_O;
    dat_n       = DAT_O;
    rsp_valid_n = 1'b0;
    rsp_rdata_n = RSP_RDATA;
    rsp_err_n   = RSP_ERR;
`ifdef WB_BYTE_MASTER_TIMEOUT_EN
    cnt_n       = cnt;
`endif

    case (state)
      IDLE: begin
        if (CMD_VALID) begin
          stb_n   = 1'b1;
          we_n    = CMD_WE;
          dat_n   = CMD_WDATA;
          state_n = REQ;
`ifdef WB_BYTE_MASTER_TIMEOUT_EN
          cnt_n   = '0;
`endif
        end
      end

      REQ: begin
        if (ACK_I) begin
          stb_n       = 1'b0;
          we_n        = 1'b0;
          rsp_valid_n = 1'b1;
          rsp_err_n   = 1'b0;
          if (!WE_O) begin
            rsp_rdata_n = DAT_I;
          end
          state_n = RSP;
        end
`ifdef WB_BYTE_MASTER_TIMEOUT_EN
        // ACK on the final cycle takes priority over the timeout.
        else if (cnt == CNT_LAST) begin
          stb_n       = 1'b0;
          we_n        = 1'b0;
          rsp_valid_n = 1'b1;
          rsp_err_n   = 1'b1;
          state_n     = RSP;
        end else if (cnt != CNT_MAX) begin
          cnt_n = cnt + CW'(1);
        end
`endif
      end

      RSP: begin
        state_n = IDLE;
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule
